// File: rtl/bfly_rnd_stage_mod13.sv
// Round/saturate stage plus radix-2 butterfly placed after the twiddle multiplier, with frame tracking.
// Optional feature: define SAT_CNT_EN to add the 16-bit saturation event counter port sat_cnt.
module bfly_rnd_stage_mod13 #(
    parameter int LANES  = 8,
    parameter int IN_W   = 25,
    parameter int MID_W  = 16,
    parameter int SHIFT  = 7,
    parameter int N_PTS  = 512,
    parameter int ADDR_W = 9
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            in_valid,
    input  logic                            clr_sat,
    input  logic [LANES-1:0][IN_W-1:0]      din_R_add,
    input  logic [LANES-1:0][IN_W-1:0]      din_Q_add,
    input  logic [LANES-1:0][IN_W-1:0]      din_R_sub,
    input  logic [LANES-1:0][IN_W-1:0]      din_Q_sub,
    output logic [LANES-1:0][MID_W:0]       dout_R_add,
    output logic [LANES-1:0][MID_W:0]       dout_Q_add,
    output logic [LANES-1:0][MID_W:0]       dout_R_sub,
    output logic [LANES-1:0][MID_W:0]       dout_Q_sub,
    output logic                            out_valid,
    output logic [ADDR_W-1:0]               addr_out,
    output logic                            frame_done,
    output logic                            sat_flag
`ifdef SAT_CNT_EN
    ,
    output logic [15:0]                     sat_cnt
`endif
);

    localparam logic signed [IN_W:0] RND_C = (IN_W+1)'(1) << (SHIFT-1);
    localparam logic signed [IN_W:0] MAX_V = {{(IN_W-MID_W+2){1'b0}}, {(MID_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = ~MAX_V;
    localparam logic [ADDR_W-1:0]    STEP  = ADDR_W'(LANES);
    localparam logic [ADDR_W-1:0]    LAST  = ADDR_W'(N_PTS - LANES);

    // Rounds half toward +inf, then clips; bit MID_W of the result flags a clip.
    function automatic logic [MID_W:0] round_sat(input logic [IN_W-1:0] x);
        logic signed [IN_W:0] ext;
        logic signed [IN_W:0] shr;
        logic [MID_W:0]       res;
        ext = $signed({x[IN_W-1], x});
        shr = (ext + RND_C) >>> SHIFT;
        if (shr > MAX_V) begin
            res = {1'b1, MAX_V[MID_W-1:0]};
        end else if (shr < MIN_V) begin
            res = {1'b1, MIN_V[MID_W-1:0]};
        end else begin
            res = {1'b0, shr[MID_W-1:0]};
        end
        return res;
    endfunction

    logic [LANES-1:0][MID_W:0]   rs_ra_s;
    logic [LANES-1:0][MID_W:0]   rs_qa_s;
    logic [LANES-1:0][MID_W:0]   rs_rb_s;
    logic [LANES-1:0][MID_W:0]   rs_qb_s;
    logic                        sat_any_s;
    logic                        sat_ev_s;

    logic [LANES-1:0][MID_W-1:0] s1_ra_r;
    logic [LANES-1:0][MID_W-1:0] s1_qa_r;
    logic [LANES-1:0][MID_W-1:0] s1_rb_r;
    logic [LANES-1:0][MID_W-1:0] s1_qb_r;
    logic                        v1_r;

    logic [LANES-1:0][MID_W:0]   bf_ra_s;
    logic [LANES-1:0][MID_W:0]   bf_qa_s;
    logic [LANES-1:0][MID_W:0]   bf_rs_s;
    logic [LANES-1:0][MID_W:0]   bf_qs_s;

    logic [ADDR_W-1:0]           cnt_r;

    // Per-lane round/saturate of all four components and the any-clip summary.
    always_comb begin
        rs_ra_s   = '0;
        rs_qa_s   = '0;
        rs_rb_s   = '0;
        rs_qb_s   = '0;
        sat_any_s = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            rs_ra_s[l] = round_sat(din_R_add[l]);
            rs_qa_s[l] = round_sat(din_Q_add[l]);
            rs_rb_s[l] = round_sat(din_R_sub[l]);
            rs_qb_s[l] = round_sat(din_Q_sub[l]);
            sat_any_s  = sat_any_s | rs_ra_s[l][MID_W] | rs_qa_s[l][MID_W]
                                   | rs_rb_s[l][MID_W] | rs_qb_s[l][MID_W];
        end
        sat_ev_s = in_valid & sat_any_s;
    end

    // S1 registers: capture rounded values on in_valid, hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_ra_r <= '0;
            s1_qa_r <= '0;
            s1_rb_r <= '0;
            s1_qb_r <= '0;
            v1_r    <= 1'b0;
        end else begin
            v1_r <= in_valid;
            if (in_valid) begin
                for (int l = 0; l < LANES; l++) begin
                    s1_ra_r[l] <= rs_ra_s[l][MID_W-1:0];
                    s1_qa_r[l] <= rs_qa_s[l][MID_W-1:0];
                    s1_rb_r[l] <= rs_rb_s[l][MID_W-1:0];
                    s1_qb_r[l] <= rs_qb_s[l][MID_W-1:0];
                end
            end
        end
    end

    // Butterfly: 16-bit operands sign-extended, so 17 bits always hold the sum and difference.
    always_comb begin
        bf_ra_s = '0;
        bf_qa_s = '0;
        bf_rs_s = '0;
        bf_qs_s = '0;
        for (int l = 0; l < LANES; l++) begin
            bf_ra_s[l] = {s1_ra_r[l][MID_W-1], s1_ra_r[l]} + {s1_rb_r[l][MID_W-1], s1_rb_r[l]};
            bf_qa_s[l] = {s1_qa_r[l][MID_W-1], s1_qa_r[l]} + {s1_qb_r[l][MID_W-1], s1_qb_r[l]};
            bf_rs_s[l] = {s1_ra_r[l][MID_W-1], s1_ra_r[l]} - {s1_rb_r[l][MID_W-1], s1_rb_r[l]};
            bf_qs_s[l] = {s1_qa_r[l][MID_W-1], s1_qa_r[l]} - {s1_qb_r[l][MID_W-1], s1_qb_r[l]};
        end
    end

    // S2 output registers and frame position tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_R_add <= '0;
            dout_Q_add <= '0;
            dout_R_sub <= '0;
            dout_Q_sub <= '0;
            out_valid  <= 1'b0;
            addr_out   <= '0;
            frame_done <= 1'b0;
            cnt_r      <= '0;
        end else begin
            out_valid <= v1_r;
            if (v1_r) begin
                dout_R_add <= bf_ra_s;
                dout_Q_add <= bf_qa_s;
                dout_R_sub <= bf_rs_s;
                dout_Q_sub <= bf_qs_s;
                addr_out   <= cnt_r;
                frame_done <= (cnt_r == LAST);
                cnt_r      <= (cnt_r == LAST) ? '0 : cnt_r + STEP;
            end else begin
                frame_done <= 1'b0;
            end
        end
    end

    // Sticky saturation flag; a new clip beats a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_flag <= 1'b0;
        end else if (sat_ev_s) begin
            sat_flag <= 1'b1;
        end else if (clr_sat) begin
            sat_flag <= 1'b0;
        end else begin
            sat_flag <= sat_flag;
        end
    end

`ifdef SAT_CNT_EN
    // Saturating count of clipping S1 cycles; clear then increment gives 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_cnt <= 16'h0000;
        end else if (clr_sat) begin
            sat_cnt <= sat_ev_s ? 16'h0001 : 16'h0000;
        end else if (sat_ev_s && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'h0001;
        end else begin
            sat_cnt <= sat_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_bfly_rnd_stage_mod13.sv
// Self-checking bench for bfly_rnd_stage_mod13: directed spec cases plus randomized streams
// compared against an integer reference model of round/saturate, butterfly and frame count.
module tb_bfly_rnd_stage_mod13;
    localparam int LANES  = 8;
    localparam int IN_W   = 25;
    localparam int MID_W  = 16;
    localparam int ADDR_W = 9;

    typedef struct packed {
        logic [LANES-1:0][MID_W:0] ra;
        logic [LANES-1:0][MID_W:0] qa;
        logic [LANES-1:0][MID_W:0] rs;
        logic [LANES-1:0][MID_W:0] qs;
    } exp_t;

    logic                       clk;
    logic                       rstn;
    logic                       in_valid;
    logic                       clr_sat;
    logic [LANES-1:0][IN_W-1:0] din_R_add;
    logic [LANES-1:0][IN_W-1:0] din_Q_add;
    logic [LANES-1:0][IN_W-1:0] din_R_sub;
    logic [LANES-1:0][IN_W-1:0] din_Q_sub;
    logic [LANES-1:0][MID_W:0]  dout_R_add;
    logic [LANES-1:0][MID_W:0]  dout_Q_add;
    logic [LANES-1:0][MID_W:0]  dout_R_sub;
    logic [LANES-1:0][MID_W:0]  dout_Q_sub;
    logic                       out_valid;
    logic [ADDR_W-1:0]          addr_out;
    logic                       frame_done;
    logic                       sat_flag;
`ifdef SAT_CNT_EN
    logic [15:0]                sat_cnt;
`endif

    bfly_rnd_stage_mod13 dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .clr_sat    (clr_sat),
        .din_R_add  (din_R_add),
        .din_Q_add  (din_Q_add),
        .din_R_sub  (din_R_sub),
        .din_Q_sub  (din_Q_sub),
        .dout_R_add (dout_R_add),
        .dout_Q_add (dout_Q_add),
        .dout_R_sub (dout_R_sub),
        .dout_Q_sub (dout_Q_sub),
        .out_valid  (out_valid),
        .addr_out   (addr_out),
        .frame_done (frame_done),
        .sat_flag   (sat_flag)
`ifdef SAT_CNT_EN
        ,
        .sat_cnt    (sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int in_ra[LANES];
    int in_qa[LANES];
    int in_rb[LANES];
    int in_qb[LANES];

    // Reference rounding: add half an LSB of the Q1.7 scale, floor-divide by 128, clip.
    function automatic int ref_rs(input int x);
        int r;
        r = (x + 64) >>> 7;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic bit ref_clips(input int x);
        int r;
        r = (x + 64) >>> 7;
        return (r > 32767) || (r < -32768);
    endfunction

    function automatic exp_t ref_vec();
        exp_t e;
        for (int i = 0; i < LANES; i++) begin
            e.ra[i] = 17'(ref_rs(in_ra[i]) + ref_rs(in_rb[i]));
            e.qa[i] = 17'(ref_rs(in_qa[i]) + ref_rs(in_qb[i]));
            e.rs[i] = 17'(ref_rs(in_ra[i]) - ref_rs(in_rb[i]));
            e.qs[i] = 17'(ref_rs(in_qa[i]) - ref_rs(in_qb[i]));
        end
        return e;
    endfunction

    function automatic int rnd_val();
        int m;
        m = $urandom_range(2);
        if (m == 0) return int'($signed(25'($urandom)));
        else if (m == 1) return $urandom_range(8388607) - 4194304;
        else return $urandom_range(16383) - 8192;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v);
        in_valid = v;
        for (int i = 0; i < LANES; i++) begin
            din_R_add[i] = IN_W'(in_ra[i]);
            din_Q_add[i] = IN_W'(in_qa[i]);
            din_R_sub[i] = IN_W'(in_rb[i]);
            din_Q_sub[i] = IN_W'(in_qb[i]);
        end
    endtask

    task automatic set_all(input int ra, input int qa, input int rb, input int qb);
        for (int i = 0; i < LANES; i++) begin
            in_ra[i] = ra; in_qa[i] = qa; in_rb[i] = rb; in_qb[i] = qb;
        end
    endtask

    task automatic set_rand();
        for (int i = 0; i < LANES; i++) begin
            in_ra[i] = rnd_val(); in_qa[i] = rnd_val();
            in_rb[i] = rnd_val(); in_qb[i] = rnd_val();
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        clr_sat  = 1'b0;
        rstn     = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        set_all(0, 0, 0, 0);
        drive(1'b0);
        do_reset();
        checks++;
        if ({out_valid, frame_done, sat_flag} !== 3'b000 || addr_out !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl got valid=%0b done=%0b sat=%0b addr=%0d want 0 0 0 0",
                     out_valid, frame_done, sat_flag, addr_out);
        end
        checks++;
        if (dout_R_add !== '0 || dout_Q_add !== '0 || dout_R_sub !== '0 || dout_Q_sub !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h want 0", dout_R_add, dout_R_sub);
        end
`ifdef SAT_CNT_EN
        checks++;
        if (sat_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_satcnt got %0d want 0", sat_cnt);
        end
`endif
    endtask

    task automatic test_rounding();
        int din_t[3] = '{64, -64, -65};
        int exp_t_[3] = '{1, 0, -1};
        for (int k = 0; k < 3; k++) begin
            set_all(din_t[k], 0, 0, 0);
            drive(1'b1);
            tick();
            drive(1'b0);
            tick();
            for (int i = 0; i < LANES; i++) begin
                checks++;
                if (out_valid !== 1'b1 || int'($signed(dout_R_add[i])) != exp_t_[k]
                    || int'($signed(dout_R_sub[i])) != exp_t_[k] || dout_Q_add[i] !== 17'd0) begin
                    errors++;
                    $display("FAIL round_%0d lane %0d got valid=%0b add=%0d sub=%0d want 1 %0d %0d",
                             din_t[k], i, out_valid, $signed(dout_R_add[i]),
                             $signed(dout_R_sub[i]), exp_t_[k], exp_t_[k]);
                end
            end
            tick();
            checks++;
            if (out_valid !== 1'b0 || int'($signed(dout_R_add[0])) != exp_t_[k]) begin
                errors++;
                $display("FAIL round_hold got valid=%0b add=%0d want 0 %0d",
                         out_valid, $signed(dout_R_add[0]), exp_t_[k]);
            end
        end
    endtask

    task automatic test_butterfly();
        set_all(1280, -384, 640, 128);
        drive(1'b1);
        tick();
        drive(1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bfly_latency_t1 got valid=%0b want 0", out_valid);
        end
        tick();
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (out_valid !== 1'b1 || int'($signed(dout_R_add[i])) != 15
                || int'($signed(dout_R_sub[i])) != 5 || int'($signed(dout_Q_add[i])) != -2
                || int'($signed(dout_Q_sub[i])) != -4) begin
                errors++;
                $display("FAIL bfly lane %0d got v=%0b %0d %0d %0d %0d want 1 15 5 -2 -4", i,
                         out_valid, $signed(dout_R_add[i]), $signed(dout_R_sub[i]),
                         $signed(dout_Q_add[i]), $signed(dout_Q_sub[i]));
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_all(16777215, 0, 0, 0);
        drive(1'b1);
        tick();
        drive(1'b0);
        checks++;
        if (sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_flag_set got %0b want 1", sat_flag);
        end
        tick();
        checks++;
        if (int'($signed(dout_R_add[3])) != 32767 || int'($signed(dout_R_sub[3])) != 32767) begin
            errors++;
            $display("FAIL sat_pos got %0d %0d want 32767 32767",
                     $signed(dout_R_add[3]), $signed(dout_R_sub[3]));
        end
`ifdef SAT_CNT_EN
        checks++;
        if (sat_cnt !== 16'd1) begin
            errors++;
            $display("FAIL satcnt_one got %0d want 1", sat_cnt);
        end
`endif
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear got %0b want 0", sat_flag);
        end
        set_all(0, 0, -16777216, 0);
        drive(1'b1);
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        drive(1'b0);
        checks++;
        if (sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_beats_clr got %0b want 1", sat_flag);
        end
`ifdef SAT_CNT_EN
        checks++;
        if (sat_cnt !== 16'd1) begin
            errors++;
            $display("FAIL satcnt_clr_inc got %0d want 1", sat_cnt);
        end
`endif
        tick();
        checks++;
        if (int'($signed(dout_R_add[5])) != -32768 || int'($signed(dout_R_sub[5])) != 32768) begin
            errors++;
            $display("FAIL sat_neg got %0d %0d want -32768 32768",
                     $signed(dout_R_add[5]), $signed(dout_R_sub[5]));
        end
        set_all(100, 100, 100, 100);
        drive(1'b1);
        tick();
        drive(1'b0);
        tick();
        checks++;
        if (sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_sticky got %0b want 1", sat_flag);
        end
    endtask

    // Random back-to-back/gapped stream with a queue scoreboard, data, hold and addr checks.
    task automatic test_random();
        exp_t q[$];
        exp_t e;
        exp_t last;
        bit   prev_v;
        bit   v;
        bit   exp_sat;
        int   n_out;
        do_reset();
        last    = '0;
        prev_v  = 1'b0;
        n_out   = 0;
        exp_sat = 1'b0;
        for (int c = 0; c < 302; c++) begin
            v = (c < 300) && ($urandom_range(3) != 0);
            if (v) begin
                set_rand();
                q.push_back(ref_vec());
                for (int i = 0; i < LANES; i++)
                    exp_sat |= ref_clips(in_ra[i]) | ref_clips(in_qa[i])
                             | ref_clips(in_rb[i]) | ref_clips(in_qb[i]);
            end
            drive(v);
            tick();
            checks++;
            if (out_valid !== prev_v) begin
                errors++;
                $display("FAIL rand_valid cyc %0d got %0b want %0b", c, out_valid, prev_v);
            end
            if (prev_v && q.size() > 0) begin
                e = q.pop_front();
                last = e;
                checks++;
                if (dout_R_add !== e.ra || dout_Q_add !== e.qa || dout_R_sub !== e.rs
                    || dout_Q_sub !== e.qs) begin
                    errors++;
                    $display("FAIL rand_data cyc %0d got ra=%h rs=%h want ra=%h rs=%h",
                             c, dout_R_add, dout_R_sub, e.ra, e.rs);
                end
                checks++;
                if (addr_out !== ADDR_W'((n_out * 8) % 512)) begin
                    errors++;
                    $display("FAIL rand_addr cyc %0d got %0d want %0d", c, addr_out, (n_out * 8) % 512);
                end
                n_out++;
            end else begin
                checks++;
                if (dout_R_add !== last.ra || dout_Q_sub !== last.qs) begin
                    errors++;
                    $display("FAIL rand_hold cyc %0d got %h want %h", c, dout_R_add, last.ra);
                end
            end
            prev_v = v;
        end
        checks++;
        if (q.size() != 0 || sat_flag !== exp_sat) begin
            errors++;
            $display("FAIL rand_drain got left=%0d sat=%0b want 0 %0b", q.size(), sat_flag, exp_sat);
        end
    endtask

    task automatic test_frame(input bit gaps);
        bit prev_v;
        bit v;
        int sent;
        int n_out;
        int want_addr;
        do_reset();
        set_all(0, 0, 0, 0);
        prev_v = 1'b0;
        sent   = 0;
        n_out  = 0;
        for (int c = 0; c < 400 && n_out < 65; c++) begin
            v = (sent < 65) && (!gaps || (c % 4 == 0));
            if (v) sent++;
            drive(v);
            tick();
            if (prev_v) begin
                want_addr = (n_out * 8) % 512;
                checks++;
                if (out_valid !== 1'b1 || addr_out !== ADDR_W'(want_addr)
                    || frame_done !== (want_addr == 504)) begin
                    errors++;
                    $display("FAIL frame_%0b vec %0d got v=%0b addr=%0d done=%0b want 1 %0d %0b", gaps,
                             n_out, out_valid, addr_out, frame_done, want_addr, want_addr == 504);
                end
                n_out++;
            end else begin
                checks++;
                if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_gap_%0b cyc %0d got v=%0b done=%0b want 0 0",
                             gaps, c, out_valid, frame_done);
                end
            end
            prev_v = v;
        end
        drive(1'b0);
        checks++;
        if (n_out != 65) begin
            errors++;
            $display("FAIL frame_count_%0b got %0d want 65", gaps, n_out);
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        do_reset();
        set_all(16777215, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1);
            tick();
        end
        checks++;
        if (sat_flag !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pre got sat=%0b v=%0b want 1 1", sat_flag, out_valid);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({out_valid, frame_done, sat_flag} !== 3'b000 || addr_out !== 9'd0
            || dout_R_add !== '0 || dout_R_sub !== '0) begin
            errors++;
            $display("FAIL midframe_async got v=%0b sat=%0b addr=%0d ra=%h want 0 0 0 0",
                     out_valid, sat_flag, addr_out, dout_R_add);
        end
`ifdef SAT_CNT_EN
        checks++;
        if (sat_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL midframe_satcnt got %0d want 0", sat_cnt);
        end
`endif
        drive(1'b0);
        tick();
        rstn = 1'b1;
        repeat (2) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midframe_flush got v=%0b want 0", out_valid);
            end
        end
        set_rand();
        e = ref_vec();
        drive(1'b1);
        tick();
        drive(1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b1 || addr_out !== 9'd0 || dout_R_add !== e.ra || dout_Q_sub !== e.qs) begin
            errors++;
            $display("FAIL midframe_restart got v=%0b addr=%0d ra=%h want 1 0 %h",
                     out_valid, addr_out, dout_R_add, e.ra);
        end
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        clr_sat   = 1'b0;
        din_R_add = '0;
        din_Q_add = '0;
        din_R_sub = '0;
        din_Q_sub = '0;
        test_reset();
        test_rounding();
        test_butterfly();
        test_saturation();
        test_random();
        test_frame(1'b0);
        test_frame(1'b1);
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
